rs232_tx_arbiter: RTL
=====================

Name: rs232_tx_arbiter

Overview:
Shares one RS-232 byte transmitter between NREQ requesters. Each requester sends a message, which is a burst of bytes terminated by a last flag. Grants are issued round-robin per whole message, and each message is optionally prefixed with an ASCII channel tag. The block sits between on-chip producers (debug dumpers, status reporters) and the transmitter's start/data/busy interface, and it sequences every byte launch.

Parameters:
NREQ, 4, number of requesters (2..8)
TAG_EN, 1, 1 = emit tag byte 8'h30+index before each message's first data byte
BUSY_TO, 8, cycles to wait for tx_busy to rise after a start pulse before flagging an error

Ports:
CLK50MHZ  in  1  system clock; all logic on rising edge
RST  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester: a byte is valid on data
last  in  NREQ  per-requester: current byte ends the message
data  in  8*NREQ  per-requester byte; slice i = data[8i+7:8i]
ack  out  NREQ  one-cycle pulse; the byte of requester i was taken
grant  out  NREQ  one-hot; owner of the transmitter for the current message
tx_start  out  1  one-cycle launch pulse to the transmitter
tx_data  out  8  registered byte, stable from the tx_start cycle until busy falls
tx_busy  in  1  transmitter busy
err  out  1  sticky; set on busy timeout, cleared only by reset

Behaviour:
- Reset (asynchronous, RST=0): state IDLE; ack=0, grant=0, tx_start=0, tx_data=8'h00, err=0; round-robin pointer=0. If reset hits mid-byte, the byte already launched completes on the line, but the arbiter forgets it.
- States: IDLE, ARB, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req bit is set and tx_busy=0, go to ARB.
  - If tx_busy=1, wait in IDLE.
- ARB:
  - Pick the first set req at or after the pointer, scanning upward with wrap.
  - Register a one-hot grant and set the flag is_tag=TAG_EN. Go to SEND.
  - If req has dropped by now, return to IDLE with grant=0.
- SEND, single cycle, tx_start=1:
  - If is_tag: tx_data=8'h30+granted index; no ack.
  - Else: tx_data=data slice of the grantee; ack[grantee]=1; capture last into msg_end.
  - Go to WAIT_HI.
- WAIT_HI:
  - Wait for tx_busy=1, then go to WAIT_LO.
  - Counter starts at 0 in SEND. If it reaches BUSY_TO-1 without busy, set err and go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0, then:
  - If is_tag: clear is_tag. If req[grantee]=1, go to SEND; otherwise end the message.
  - Else, if msg_end=1 or req[grantee]=0: end the message.
  - Else: go to SEND.
- End of message: grant=0; pointer=(grantee+1) mod NREQ; go to IDLE.
- Throughput: minimum gap between a busy fall and the next tx_start is 1 cycle (the WAIT_LO→SEND transition).
- Requester rules:
  - Hold req, data and last stable until ack.
  - After ack, present the next byte before busy falls, or drop req to abandon. Abandoning ends the message after the byte in flight.
- Non-grantee req bits are ignored while a grant is held. grant stays constant for the whole message.
- Simultaneous events:
  - A req rising in the same cycle a message ends is eligible in the next ARB.
  - last and req-drop in the same byte both just end the message.
- Width rules:
  - Pointer is ceil(log2(NREQ)) bits and wraps modulo NREQ, not 2^width.
  - Tag arithmetic is 8-bit; NREQ≤8 keeps tags within '0'..'7'.

Decomposition:
- Shared package: state encoding constants, TAG_BASE=8'h30, and the pointer-width function (the existing generic log2 include).
- One natural sub-module, rr_pick: combinational round-robin selector (req, pointer → one-hot, valid). It is reused by future shared-resource arbiters.

Test Plan:
1. Reset with req=4'b0001 held → all outputs 0, err=0. After release, within 2 cycles: grant=0001, tx_start with tx_data=8'h30.
2. Requester 2 sends 3 bytes 8'h41,8'h42,8'h43 (last on the third), transmitter model with busy for 10 cycles → line order 8'h32,41,42,43; three ack pulses on req 2; grant released one cycle after the final busy fall.
3. req=4'b1111, each sending 1-byte messages, pointer=0 → messages granted in order 0,1,2,3, then 0 again; no requester granted twice before every other one has been served.
4. TAG_EN=0, requester 1 drops req after its first ack (no last) → exactly one byte sent, grant cleared, next arbitration starts at requester 2.
5. Transmitter model that never raises busy → err=1 after BUSY_TO=8 cycles; FSM still returns to IDLE; err persists until RST=0.
6. Assert RST=0 during WAIT_LO of byte 2 of 4 → outputs zero immediately (asynchronous). After release, arbitration restarts with pointer=0 and a fresh tag.

Source files
------------

// File: rtl/rs232_tx_arbiter_pkg.sv
// Shared types and helpers for the RS-232 transmitter arbiter and its round-robin selector.
package rs232_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StSend,
    StWaitHi,
    StWaitLo
  } state_e;

  localparam logic [7:0] TagBase = 8'h30;

  // Index width for n entries, never less than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping modulo N.
module rs232_tx_arbiter_rr_pick
  import rs232_tx_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = ptr_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  logic         found;
  logic [W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = W'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Shares one RS-232 byte transmitter between NREQ requesters, granting whole messages
// round-robin and optionally prefixing each message with an ASCII channel tag.
module rs232_tx_arbiter
  import rs232_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter bit          TAG_EN  = 1'b1,
  parameter int unsigned BUSY_TO = 8
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              err
);

  localparam int unsigned     PtrW    = ptr_width(NREQ);
  localparam int unsigned     CntW    = ptr_width(BUSY_TO);
  localparam logic [CntW-1:0] CntMax  = CntW'(BUSY_TO - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0] gidx_q, gidx_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            is_tag_q, is_tag_d;
  logic            msg_end_q, msg_end_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic [PtrW-1:0] pick_idx;
  logic [7:0]      pick_byte;
  logic [7:0]      gnt_byte;
  logic            next_send;
  logic            end_msg;

  rs232_tx_arbiter_rr_pick #(
    .N(NREQ)
  ) u_rr_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .valid_o(pick_valid)
  );

  always_comb begin
    pick_idx  = '0;
    pick_byte = '0;
    gnt_byte  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx  = PtrW'(i);
        pick_byte = data[8*i +: 8];
      end
      if (gidx_q == PtrW'(i)) gnt_byte = data[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    is_tag_d  = is_tag_q;
    msg_end_d = msg_end_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    ack       = '0;
    tx_start  = 1'b0;
    next_send = 1'b0;
    end_msg   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req && !tx_busy) state_d = StArb;
      end
      StArb: begin
        if (pick_valid) begin
          grant_d   = pick_gnt;
          gidx_d    = pick_idx;
          is_tag_d  = TAG_EN;
          tx_data_d = TAG_EN ? (TagBase + 8'(pick_idx)) : pick_byte;
          state_d   = StSend;
        end else begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      StSend: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        if (!is_tag_q) begin
          ack       = grant_q;
          msg_end_d = last[gidx_q];
        end
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (tx_busy) begin
          state_d = StWaitLo;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = StWaitLo;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLo: begin
        if (!tx_busy) begin
          if (is_tag_q) begin
            is_tag_d = 1'b0;
            if (req[gidx_q]) next_send = 1'b1;
            else             end_msg   = 1'b1;
          end else if (msg_end_q || !req[gidx_q]) begin
            end_msg = 1'b1;
          end else begin
            next_send = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The requester has already placed its next byte by the time busy falls.
    if (next_send) begin
      tx_data_d = gnt_byte;
      state_d   = StSend;
    end
    if (end_msg) begin
      grant_d = '0;
      ptr_d   = (gidx_q == PtrLast) ? '0 : gidx_q + 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      is_tag_q  <= 1'b0;
      msg_end_q <= 1'b0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      is_tag_q  <= is_tag_d;
      msg_end_q <= msg_end_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;
  assign err     = err_q;

endmodule
